// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: default bus widths, the
// word presented to decode when nothing valid is at the buffer head, and the
// fetch controller state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Value driven on inst_out whenever inst_valid is low
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // IDLE: nothing outstanding
    // BUSY: one request outstanding, its data is wanted
    // DISCARD: one request outstanding, its data must be dropped
    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_BUSY    = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small fetch buffer between instruction memory and decode. DEPTH entries of
// WIDTH bits, with push, pop and a flush that empties it in one cycle. The
// head entry is always visible on rdata_o; count_o reports occupancy.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   flush_i  in   empty the buffer (pushes in the same cycle are discarded)
//   push_i   in   write wdata_i at the tail
//   pop_i    in   remove the head entry
//   wdata_i  in   WIDTH-bit entry to write
//   rdata_o  out  WIDTH-bit head entry (meaningful only when count_o != 0)
//   count_o  out  occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // modulo DEPTH by simply overflowing.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // The issue logic upstream never lets a push land on a full buffer unless
    // the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && !flush_i) begin
            assert (!(push_i && !pop_i && (count_q == CW'(DEPTH))));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting right after the PC logic. Issues at most one
// outstanding instruction-memory request, buffers returned words for decode in
// fetch_fifo, and drives pc_advance as the PC register write enable. A redirect
// flushes the buffer and drops any in-flight fetch.
// Configuration macro: FETCH_BYPASS_EN -- when defined, a word returning into an
// empty buffer is shown to decode in its ack cycle (consumed without a push if
// decode is ready). When undefined, every word goes through the buffer.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   pc_addr     in   current PC
//   pc_plus4    in   PC+4 of the current PC
//   redirect    in   PC is loaded with a branch/jump target this edge
//   pc_advance  out  PC write enable for sequential fetch (combinational)
//   imem_req    out  memory request valid (registered)
//   imem_addr   out  request address, stable while imem_req is high
//   imem_ack    in   request complete, imem_data valid this cycle
//   imem_data   in   fetched word
//   inst_valid  out  inst_out/inst_pc4 valid to decode
//   inst_out    out  instruction at buffer head
//   inst_pc4    out  PC+4 of that instruction
//   dec_ready   in   decode consumes the head when inst_valid is high
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc4,
    input  logic              dec_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic               imem_req_q;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0]  req_pc4_q, req_pc4_d;

    logic               ack_busy;
    logic               bypass;
    logic               fifo_valid;
    logic               push;
    logic               pop;
    logic               issue;
    logic [CW-1:0]      occ_next;
    logic [CW-1:0]      fifo_count;
    logic [DATA_W+ADDR_W-1:0] fifo_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem_data, req_pc4_q}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    // Handshake, buffer control, issue decision, next state and decode-side
    // outputs. Issue looks at the occupancy after this cycle's push/pop so a
    // request is only launched when its data is guaranteed a free slot.
    always_comb begin
        ack_busy   = (state_q == FS_BUSY) && imem_ack;
        fifo_valid = (fifo_count != '0);
        bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass     = ack_busy && !redirect && !fifo_valid;
`endif
        pop      = fifo_valid && dec_ready;
        push     = ack_busy && !redirect && !(bypass && dec_ready);
        occ_next = fifo_count + CW'(push) - CW'(pop);
        issue    = ((state_q == FS_IDLE) || ack_busy) && (occ_next < DEPTH_C)
                   && !redirect && !reset;

        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        req_pc4_d   = req_pc4_q;

        case (state_q)
            FS_IDLE: begin
                state_d = FS_IDLE;
            end
            FS_BUSY: begin
                if (redirect) begin
                    state_d = imem_ack ? FS_IDLE : FS_DISCARD;
                end else if (imem_ack) begin
                    state_d = FS_IDLE;
                end
            end
            FS_DISCARD: begin
                if (imem_ack) begin
                    state_d = FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        if (issue) begin
            state_d     = FS_BUSY;
            imem_addr_d = pc_addr;
            req_pc4_d   = pc_plus4;
        end

        pc_advance = issue;
        inst_valid = fifo_valid || bypass;
        inst_out   = DATA_W'(NOP_WORD);
        inst_pc4   = '0;
        if (bypass) begin
            inst_out = imem_data;
            inst_pc4 = req_pc4_q;
        end else if (fifo_valid) begin
            inst_out = fifo_rdata[DATA_W+ADDR_W-1:ADDR_W];
            inst_pc4 = fifo_rdata[ADDR_W-1:0];
        end
    end

    // Controller registers. A request is outstanding exactly when the
    // controller is not idle, so imem_req follows the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            req_pc4_q   <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= (state_d != FS_IDLE);
            imem_addr_q <= imem_addr_d;
            req_pc4_q   <= req_pc4_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit with a PC register, a memory responder with configurable
// ack latency and a decode stage, and compares every cycle against a
// transaction-level model: one outstanding request (possibly marked to be
// dropped) and a queue of buffered words.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc4;
    logic        dec_ready;

    int checks = 0;
    int errors = 0;

    // Model of the fetch stage at transaction level
    bit          mOut;
    bit          mDrop;
    logic [31:0] mAddr;
    logic [31:0] mPc4;
    int          mWait;
    int          mLat;
    logic [31:0] qData[$];
    logic [31:0] qPc4[$];

    // Environment
    logic [31:0] pc;
    int          latCfg;
    bit          forceAck;
    bit          useOvr;
    logic [31:0] ovrData;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_plus4   (pc_plus4),
        .redirect   (redirect),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc4   (inst_pc4),
        .dec_ready  (dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input bit expAdv, input bit expReq, input logic [31:0] expAddr,
                               input bit expValid, input logic [31:0] expOut,
                               input logic [31:0] expPc4);
        checkVal("pc_advance", 32'(pc_advance), 32'(expAdv));
        checkVal("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) checkVal("imem_addr", imem_addr, expAddr);
        checkVal("inst_valid", 32'(inst_valid), 32'(expValid));
        if (expValid) begin
            checkVal("inst_out", inst_out, expOut);
            checkVal("inst_pc4", inst_pc4, expPc4);
        end
    endtask

    task automatic doReset(input logic [31:0] newPc);
        @(negedge clk);
        reset     = 1'b1;
        redirect  = 1'b0;
        imem_ack  = 1'b0;
        imem_data = $urandom;
        dec_ready = 1'b0;
        pc_addr   = pc;
        pc_plus4  = pc + 32'd4;
        #1;
        checkVal("rst_pc_advance_in", 32'(pc_advance), 32'd0);
        @(posedge clk);
        #1;
        checkVal("rst_imem_req", 32'(imem_req), 32'd0);
        checkVal("rst_imem_addr", imem_addr, 32'd0);
        checkVal("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkVal("rst_inst_out", inst_out, 32'd0);
        checkVal("rst_inst_pc4", inst_pc4, 32'd0);
        checkVal("rst_pc_advance", 32'(pc_advance), 32'd0);
        qData.delete();
        qPc4.delete();
        mOut  = 1'b0;
        mDrop = 1'b0;
        mWait = 0;
        pc    = newPc;
    endtask

    // One cycle. rdMode: 0 no redirect, 1 redirect, 2 redirect only if the
    // outstanding request is acked this cycle.
    task automatic applyStimulus(input int rdMode, input logic [31:0] tgt, input bit dr);
        bit          ackNow, rdNow, ackSeen, deliver, byp, expValid, expAdv, free;
        int          occ, occAfter;
        logic [31:0] expOut, expPc4;
        @(negedge clk);
        ackNow = (mOut && (mWait >= mLat)) || forceAck;
        rdNow  = (rdMode == 1) || (rdMode == 2 && mOut && ackNow);
        reset     = 1'b0;
        redirect  = rdNow;
        imem_ack  = ackNow;
        imem_data = mOut ? (useOvr ? ovrData : memWord(mAddr)) : $urandom;
        dec_ready = dr;
        pc_addr   = pc;
        pc_plus4  = pc + 32'd4;

        ackSeen = mOut && ackNow;
        deliver = ackSeen && !mDrop && !rdNow;
        occ     = qData.size();
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp     = (occ == 0) && deliver;
`endif
        expValid = (occ > 0) || byp;
        expOut   = (occ > 0) ? qData[0] : imem_data;
        expPc4   = (occ > 0) ? qPc4[0] : mPc4;
        occAfter = occ + ((deliver && !(byp && dr)) ? 1 : 0) - ((occ > 0 && dr) ? 1 : 0);
        free     = !mOut || (ackSeen && !mDrop);
        expAdv   = free && (occAfter < DEPTH) && !rdNow;
        #1;
        checkOutput(expAdv, mOut, mAddr, expValid, expOut, expPc4);
        @(posedge clk);

        if (rdNow) begin
            qData.delete();
            qPc4.delete();
            if (mOut && !ackSeen) mDrop = 1'b1;
            else begin
                mOut  = 1'b0;
                mDrop = 1'b0;
            end
        end else begin
            if (occ > 0 && dr) begin
                void'(qData.pop_front());
                void'(qPc4.pop_front());
            end
            if (deliver && !(byp && dr)) begin
                qData.push_back(imem_data);
                qPc4.push_back(mPc4);
            end
            if (ackSeen) begin
                mOut  = 1'b0;
                mDrop = 1'b0;
            end
            if (expAdv) begin
                mOut  = 1'b1;
                mDrop = 1'b0;
                mAddr = pc;
                mPc4  = pc + 32'd4;
                mWait = 0;
                mLat  = (latCfg > 0) ? latCfg : int'($urandom_range(1, 4));
            end
        end
        if (mOut) mWait++;
        if (rdNow) pc = tgt;
        else if (expAdv) pc = pc + 32'd4;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; imem_data = '0;
        dec_ready = 1'b0; pc = '0; pc_addr = '0; pc_plus4 = 32'd4;
        mOut = 1'b0; mDrop = 1'b0; mAddr = '0; mPc4 = '0; mWait = 0; mLat = 1;
        latCfg = 1; forceAck = 1'b0; useOvr = 1'b0; ovrData = 32'hDEAD_BEEF;

        // Streaming with ack the cycle after each request, PC from 0
        doReset(32'h0);
        latCfg = 1;
        repeat (8) applyStimulus(0, 32'h0, 1'b1);

        // Decode stalled, 3-cycle memory: buffer fills to DEPTH, then one pop
        doReset(32'h0);
        latCfg = 3;
        repeat (14) applyStimulus(0, 32'h0, 1'b0);
        applyStimulus(0, 32'h0, 1'b1);
        repeat (6) applyStimulus(0, 32'h0, 1'b0);

        // Redirect while a request is outstanding; its data must vanish
        doReset(32'h40);
        latCfg = 3;
        applyStimulus(0, 32'h0, 1'b1);
        useOvr = 1'b1;
        applyStimulus(1, 32'h100, 1'b1);
        repeat (2) applyStimulus(0, 32'h0, 1'b1);
        useOvr = 1'b0;
        repeat (6) applyStimulus(0, 32'h0, 1'b1);

        // Redirect in the same cycle as an ack with one word buffered
        doReset(32'h0);
        latCfg = 1;
        repeat (2) applyStimulus(0, 32'h0, 1'b0);
        applyStimulus(2, 32'h200, 1'b0);
        repeat (5) applyStimulus(0, 32'h0, 1'b1);

        // Reset in the middle of a request, stray ack afterwards
        latCfg = 3;
        applyStimulus(0, 32'h0, 1'b1);
        applyStimulus(0, 32'h0, 1'b1);
        doReset(32'h300);
        forceAck = 1'b1;
        applyStimulus(0, 32'h0, 1'b1);
        forceAck = 1'b0;
        repeat (6) applyStimulus(0, 32'h0, 1'b1);

        // Empty buffer, decode ready, 2-cycle memory (bypass timing)
        doReset(32'h500);
        latCfg = 2;
        repeat (10) applyStimulus(0, 32'h0, 1'b1);

        // Random traffic
        latCfg = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset($urandom & 32'hFFFF_FFFC);
            end else begin
                applyStimulus(($urandom_range(0, 14) == 0) ? 1 : 0,
                              $urandom & 32'hFFFF_FFFC,
                              $urandom_range(0, 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
